// File: rtl/vga_timing_pkg.sv
// Shared timing defaults, axis phase type and the debug view of both phase FSMs.
package vga_timing_pkg;

  localparam int CNT_W = 10;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FRONT  = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BACK   = 48;
  localparam int DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;

  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FRONT  = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BACK   = 33;
  localparam int DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

  typedef enum logic [1:0] {
    PH_ACTIVE = 2'd0,
    PH_FRONT  = 2'd1,
    PH_SYNC   = 2'd2,
    PH_BACK   = 2'd3
  } phase_t;

  typedef struct packed {
    phase_t h_phase;
    phase_t v_phase;
    logic   frame_wrap;
  } dbg_t;

  // Pin level of a sync output given whether the pulse is currently asserted.
  function automatic logic sync_level(input logic asserted, input logic pol);
    return asserted ? pol : ~pol;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Pixel-coordinate stream from the timing generator to the graphics engine.
// No back-pressure: the consumer samples whenever the pixel enable is high; outputs hold otherwise.
interface vga_timing_gen_if;
  logic [9:0] x;
  logic [8:0] y;
  logic       frame_active;
  logic       h_sync;
  logic       v_sync;
  logic       line_start;
  logic       frame_start;

  modport master (
    output x, y, frame_active, h_sync, v_sync, line_start, frame_start
  );

  modport slave (
    input x, y, frame_active, h_sync, v_sync, line_start, frame_start
  );
endinterface

// File: rtl/vga_phase_counter.sv
// One raster axis: a wrapping counter plus an ACTIVE/FRONT/SYNC/BACK phase FSM.
module vga_phase_counter
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE = DEF_H_ACTIVE,
  parameter int FRONT  = DEF_H_FRONT,
  parameter int SYNC   = DEF_H_SYNC,
  parameter int BACK   = DEF_H_BACK,
  parameter int W      = CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         step,
  output logic [W-1:0] count,
  output phase_t       phase,
  output logic         wrap
);

  localparam int TOTAL = ACTIVE + FRONT + SYNC + BACK;
  localparam logic [W-1:0] LAST    = W'(TOTAL - 1);
  localparam logic [W-1:0] B_FRONT = W'(ACTIVE);
  localparam logic [W-1:0] B_SYNC  = W'(ACTIVE + FRONT);
  localparam logic [W-1:0] B_BACK  = W'(ACTIVE + FRONT + SYNC);

  logic [W-1:0] count_q, count_d;
  phase_t       phase_q, phase_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      phase_q <= PH_ACTIVE;
    end else begin
      count_q <= count_d;
      phase_q <= phase_d;
    end
  end

  // Phase follows the counter value it is about to hold, so both change on the same edge.
  always_comb begin
    count_d = count_q;
    phase_d = phase_q;
    wrap    = 1'b0;
    if (step) begin
      if (count_q == LAST) begin
        count_d = '0;
        wrap    = 1'b1;
      end else begin
        count_d = count_q + 1'b1;
      end
      case (phase_q)
        PH_ACTIVE: if (count_d == B_FRONT) phase_d = PH_FRONT;
        PH_FRONT:  if (count_d == B_SYNC)  phase_d = PH_SYNC;
        PH_SYNC:   if (count_d == B_BACK)  phase_d = PH_BACK;
        PH_BACK:   if (count_d == '0)      phase_d = PH_ACTIVE;
        default:   phase_d = PH_ACTIVE;
      endcase
    end
  end

  assign count = count_q;
  assign phase = phase_q;

endmodule

// File: rtl/vga_timing_gen.sv
// 640x480@60 raster timing generator: two axis counters feeding a bank of
// ce-gated output registers so downstream colour logic sees glitch-free inputs.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FRONT  = DEF_H_FRONT,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BACK   = DEF_H_BACK,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FRONT  = DEF_V_FRONT,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BACK   = DEF_V_BACK,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ce,
  vga_timing_gen_if.master        pix,
  output dbg_t                    dbg
);

  logic [CNT_W-1:0] hc, vc;
  phase_t           h_phase, v_phase;
  logic             h_wrap, v_wrap;

  vga_phase_counter #(
    .ACTIVE(H_ACTIVE), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK), .W(CNT_W)
  ) u_h_axis (
    .clk   (clk),
    .rst_n (rst_n),
    .step  (ce),
    .count (hc),
    .phase (h_phase),
    .wrap  (h_wrap)
  );

  vga_phase_counter #(
    .ACTIVE(V_ACTIVE), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK), .W(CNT_W)
  ) u_v_axis (
    .clk   (clk),
    .rst_n (rst_n),
    .step  (ce & h_wrap),
    .count (vc),
    .phase (v_phase),
    .wrap  (v_wrap)
  );

  logic [9:0] x_q, x_d;
  logic [8:0] y_q, y_d;
  logic       active_q, active_d;
  logic       h_sync_q, h_sync_d;
  logic       v_sync_q, v_sync_d;
  logic       line_start_q, line_start_d;
  logic       frame_start_q, frame_start_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q           <= '0;
      y_q           <= '0;
      active_q      <= 1'b0;
      h_sync_q      <= ~SYNC_POL;
      v_sync_q      <= ~SYNC_POL;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      x_q           <= x_d;
      y_q           <= y_d;
      active_q      <= active_d;
      h_sync_q      <= h_sync_d;
      v_sync_q      <= v_sync_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  // Outputs capture the counter state seen at the enabled edge, so they trail it by one enabled cycle.
  always_comb begin
    x_d           = x_q;
    y_d           = y_q;
    active_d      = active_q;
    h_sync_d      = h_sync_q;
    v_sync_d      = v_sync_q;
    line_start_d  = line_start_q;
    frame_start_d = frame_start_q;
    if (ce) begin
      x_d           = hc;
      y_d           = (v_phase == PH_ACTIVE) ? vc[8:0] : '0;
      active_d      = (h_phase == PH_ACTIVE) && (v_phase == PH_ACTIVE);
      h_sync_d      = sync_level(h_phase == PH_SYNC, SYNC_POL);
      v_sync_d      = sync_level(v_phase == PH_SYNC, SYNC_POL);
      line_start_d  = (hc == '0);
      frame_start_d = (hc == '0) && (vc == '0);
    end
  end

  assign pix.x            = x_q;
  assign pix.y            = y_q;
  assign pix.frame_active = active_q;
  assign pix.h_sync       = h_sync_q;
  assign pix.v_sync       = v_sync_q;
  assign pix.line_start   = line_start_q;
  assign pix.frame_start  = frame_start_q;

  assign dbg = {h_phase, v_phase, v_wrap};

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default 640x480 build plus two shrunken builds (both sync polarities),
// all compared every cycle against a raster model computed from the enabled-cycle count.
module tb_vga_timing_gen;
  import vga_timing_pkg::*;

  typedef struct {
    int   ha, hf, hs, hb, va, vf, vs, vb;
    logic pol;
  } timing_t;

  typedef struct {
    logic [9:0] x;
    logic [8:0] y;
    logic       fa, hs, vs, ls, fs, fw;
    phase_t     hp, vp;
  } exp_t;

  logic clk, rst_n, ce;
  int   k;
  int   checks, errors;
  timing_t t_def, t_sml, t_pol;
  dbg_t dbg_def, dbg_sml, dbg_pol;

  vga_timing_gen_if if_def ();
  vga_timing_gen_if if_sml ();
  vga_timing_gen_if if_pol ();

  vga_timing_gen u_def (
    .clk(clk), .rst_n(rst_n), .ce(ce), .pix(if_def), .dbg(dbg_def)
  );

  vga_timing_gen #(
    .H_ACTIVE(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(3),
    .V_ACTIVE(10), .V_FRONT(2), .V_SYNC(2), .V_BACK(3), .SYNC_POL(1'b0)
  ) u_sml (
    .clk(clk), .rst_n(rst_n), .ce(ce), .pix(if_sml), .dbg(dbg_sml)
  );

  vga_timing_gen #(
    .H_ACTIVE(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(3),
    .V_ACTIVE(10), .V_FRONT(2), .V_SYNC(2), .V_BACK(3), .SYNC_POL(1'b1)
  ) u_pol (
    .clk(clk), .rst_n(rst_n), .ce(ce), .pix(if_pol), .dbg(dbg_pol)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic phase_t phase_of(int c, int a, int f, int s);
    if (c < a) return PH_ACTIVE;
    if (c < a + f) return PH_FRONT;
    if (c < a + f + s) return PH_SYNC;
    return PH_BACK;
  endfunction

  // Raster model: kk enabled edges since reset; outputs show position kk-1, counters sit at position kk.
  function automatic exp_t model(int kk, timing_t t, logic ce_now);
    exp_t e;
    int ht, vt, p, hc, vc, q;
    ht = t.ha + t.hf + t.hs + t.hb;
    vt = t.va + t.vf + t.vs + t.vb;
    q = kk % (ht * vt);
    e.hp = phase_of(q % ht, t.ha, t.hf, t.hs);
    e.vp = phase_of(q / ht, t.va, t.vf, t.vs);
    e.fw = ce_now && (q == ht * vt - 1);
    if (kk == 0) begin
      e.x = '0; e.y = '0; e.fa = 1'b0; e.ls = 1'b0; e.fs = 1'b0;
      e.hs = ~t.pol; e.vs = ~t.pol;
      return e;
    end
    p  = (kk - 1) % (ht * vt);
    hc = p % ht;
    vc = p / ht;
    e.x  = 10'(hc);
    e.y  = (vc < t.va) ? 9'(vc) : 9'd0;
    e.fa = (hc < t.ha) && (vc < t.va);
    e.hs = ((hc >= t.ha + t.hf) && (hc < t.ha + t.hf + t.hs)) ? t.pol : ~t.pol;
    e.vs = ((vc >= t.va + t.vf) && (vc < t.va + t.vf + t.vs)) ? t.pol : ~t.pol;
    e.ls = (hc == 0);
    e.fs = (p == 0);
    return e;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d at k=%0d", tag, obs, exp, k);
    end
  endtask

  task automatic check_dut(string n, exp_t o, exp_t e);
    chk({n, ".x"}, 32'(o.x), 32'(e.x));
    chk({n, ".y"}, 32'(o.y), 32'(e.y));
    chk({n, ".frame_active"}, 32'(o.fa), 32'(e.fa));
    chk({n, ".h_sync"}, 32'(o.hs), 32'(e.hs));
    chk({n, ".v_sync"}, 32'(o.vs), 32'(e.vs));
    chk({n, ".line_start"}, 32'(o.ls), 32'(e.ls));
    chk({n, ".frame_start"}, 32'(o.fs), 32'(e.fs));
    chk({n, ".h_phase"}, 32'(o.hp), 32'(e.hp));
    chk({n, ".v_phase"}, 32'(o.vp), 32'(e.vp));
    chk({n, ".frame_wrap"}, 32'(o.fw), 32'(e.fw));
  endtask

  task automatic check_all();
    exp_t o;
    o.x = if_def.x; o.y = if_def.y; o.fa = if_def.frame_active; o.hs = if_def.h_sync;
    o.vs = if_def.v_sync; o.ls = if_def.line_start; o.fs = if_def.frame_start;
    o.hp = dbg_def.h_phase; o.vp = dbg_def.v_phase; o.fw = dbg_def.frame_wrap;
    check_dut("def", o, model(k, t_def, ce));
    o.x = if_sml.x; o.y = if_sml.y; o.fa = if_sml.frame_active; o.hs = if_sml.h_sync;
    o.vs = if_sml.v_sync; o.ls = if_sml.line_start; o.fs = if_sml.frame_start;
    o.hp = dbg_sml.h_phase; o.vp = dbg_sml.v_phase; o.fw = dbg_sml.frame_wrap;
    check_dut("sml", o, model(k, t_sml, ce));
    o.x = if_pol.x; o.y = if_pol.y; o.fa = if_pol.frame_active; o.hs = if_pol.h_sync;
    o.vs = if_pol.v_sync; o.ls = if_pol.line_start; o.fs = if_pol.frame_start;
    o.hp = dbg_pol.h_phase; o.vp = dbg_pol.v_phase; o.fw = dbg_pol.frame_wrap;
    check_dut("pol", o, model(k, t_pol, ce));
  endtask

  // driver: one clock with the current ce, then compare everything on the falling edge
  task automatic tick();
    @(posedge clk);
    if (rst_n && ce) k++;
    @(negedge clk);
    check_all();
  endtask

  initial begin
    int fa_cnt, hs_lo, hs_first, ls_cnt, fs_a, fs_b, vs_lo, guard;
    t_def = '{ha: 640, hf: 16, hs: 96, hb: 48, va: 480, vf: 10, vs: 2, vb: 33, pol: 1'b0};
    t_sml = '{ha: 16, hf: 2, hs: 4, hb: 3, va: 10, vf: 2, vs: 2, vb: 3, pol: 1'b0};
    t_pol = '{ha: 16, hf: 2, hs: 4, hb: 3, va: 10, vf: 2, vs: 2, vb: 3, pol: 1'b1};
    checks = 0; errors = 0; k = 0;
    rst_n = 1'b0; ce = 1'b0;

    // reset held: everything at reset values
    repeat (3) tick();

    // release with ce high; first line of the default build measured directly
    rst_n = 1'b1; ce = 1'b1;
    fa_cnt = 0; hs_lo = 0; hs_first = -1; ls_cnt = 0; fs_a = -1; fs_b = -1; vs_lo = 0;
    for (int i = 0; i < 800; i++) begin
      tick();
      if (i == 0) begin
        chk("first.x", 32'(if_def.x), 32'd0);
        chk("first.frame_active", 32'(if_def.frame_active), 32'd1);
        chk("first.frame_start", 32'(if_def.frame_start), 32'd1);
        chk("first.sync", 32'({if_def.h_sync, if_def.v_sync}), 32'd3);
      end
      if (if_def.frame_active) fa_cnt++;
      if (!if_def.h_sync) begin
        hs_lo++;
        if (hs_first < 0) hs_first = int'(if_def.x);
      end
      if (if_def.line_start) ls_cnt++;
      if (if_sml.frame_start) begin
        if (fs_a < 0) fs_a = i;
        else if (fs_b < 0) fs_b = i;
      end
      if (i < 425 && !if_sml.v_sync) vs_lo++;
    end
    chk("line.active_cycles", 32'(fa_cnt), 32'd640);
    chk("line.hsync_width", 32'(hs_lo), 32'd96);
    chk("line.hsync_start_x", 32'(hs_first), 32'd656);
    chk("line.line_start_count", 32'(ls_cnt), 32'd1);
    chk("sml.frame_period", 32'(fs_b - fs_a), 32'd425);
    chk("sml.vsync_width", 32'(vs_lo), 32'd50);
    tick();
    chk("line.period", 32'(if_def.line_start), 32'd1);

    // random pixel enable
    repeat (1500) begin
      ce = 1'($urandom_range(0, 1));
      tick();
    end

    // ce toggling every cycle (clk at twice the pixel rate)
    repeat (1000) begin
      ce = ~ce;
      tick();
    end

    // freeze at the end of the last active line of the small build
    ce = 1'b1; guard = 0;
    while (((k - 1) % 425 != 249) && guard < 1000) begin
      tick();
      guard++;
    end
    chk("freeze.reached", 32'(guard < 1000), 32'd1);
    ce = 1'b0;
    repeat (37) tick();
    chk("freeze.x", 32'(if_sml.x), 32'd24);
    chk("freeze.y", 32'(if_sml.y), 32'd9);
    ce = 1'b1;
    tick();
    chk("unfreeze.x", 32'(if_sml.x), 32'd0);
    chk("unfreeze.y", 32'(if_sml.y), 32'd0);
    chk("unfreeze.frame_active", 32'(if_sml.frame_active), 32'd0);

    // asynchronous reset mid-line at (10,5) of the small build
    guard = 0;
    while (((k - 1) % 425 != 135) && guard < 1000) begin
      tick();
      guard++;
    end
    chk("midreset.reached", 32'(guard < 1000), 32'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    k = 0;
    #1 check_all();
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    chk("restart.x", 32'(if_sml.x), 32'd0);
    chk("restart.frame_start", 32'(if_sml.frame_start), 32'd1);
    repeat (60) begin
      ce = 1'($urandom_range(0, 1));
      tick();
    end

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Generates 640×480 @ 60 Hz raster timing: horizontal/vertical counters, sync pulses, active-video flag and pixel coordinates. It is the producer end of the pixel-coordinate interface that the graphics engine consumes: `x`, `y`, `frame_active`, `v_sync`. All outputs are registered so downstream combinational colour logic sees glitch-free inputs. One instance sits at the top level, between the pixel clock and the graphics engine and output pins.

## Interface
Parameters:
- `H_ACTIVE`, default 640: visible pixels per line.
- `H_FRONT`, default 16: horizontal front porch, in pixels.
- `H_SYNC`, default 96: hsync pulse width, in pixels.
- `H_BACK`, default 48: horizontal back porch. H_TOTAL = 800.
- `V_ACTIVE`, default 480: visible lines.
- `V_FRONT`, default 10: vertical front porch, in lines.
- `V_SYNC`, default 2: vsync pulse width, in lines.
- `V_BACK`, default 33: vertical back porch. V_TOTAL = 525.
- `SYNC_POL`, default 0: sync pulse level. 0 = active-low pulses; 1 = active-high.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1: pixel clock (25.175 MHz nominal).
- `rst_n`  in  1: asynchronous, active-low reset.
- `ce`  in  1: pixel enable. Counters advance only when `ce` is 1.
- `h_sync`  out  1: horizontal sync at the `SYNC_POL` level.
- `v_sync`  out  1: vertical sync at the `SYNC_POL` level.
- `frame_active`  out  1: high only for visible pixels.
- `x`  out  10: horizontal counter `hc`, valid on every cycle (0..799).
- `y`  out  9: `vc[8:0]` on active lines; 0 on blank lines.
- `line_start`  out  1: one-cycle pulse when `hc` = 0.
- `frame_start`  out  1: one-cycle pulse when `hc` = 0 and `vc` = 0.

## Operation
- Internal counters:
  - `hc` is 10 bits, range 0..H_TOTAL-1.
  - `vc` is 10 bits, range 0..V_TOTAL-1.
  - `hc` increments on each `clk` with `ce` = 1. It wraps to 0 after H_TOTAL-1.
  - `vc` increments only on that wrap. It wraps to 0 after V_TOTAL-1.
- Each axis runs a phase FSM: ACTIVE → FRONT → SYNC → BACK → ACTIVE.
  - The FSM moves to the next phase when its counter reaches that phase's cumulative boundary.
  - Horizontal boundaries: 640, 656, 752, 0.
  - Vertical boundaries: 480, 490, 492, 0.
  - The vertical FSM only transitions on an `hc` wrap.
- Sync pulses:
  - `h_sync` is asserted while the H FSM is in SYNC, i.e. `hc` 656..751.
  - `v_sync` is asserted while the V FSM is in SYNC, i.e. lines 490..491. It changes only at line starts.
- `frame_active` = (H FSM in ACTIVE) AND (V FSM in ACTIVE).
- Output registers load only when `ce` = 1. When `ce` = 0, every output holds its value, including the pulses.
- Counters saturate nowhere; wrap is the only rollover path.
- The consumer animates on the `v_sync` rising edge. With `SYNC_POL` = 0, that edge is the end of the pulse, at the start of line 492.

## Timing
- Reset values, all asynchronous:
  - `hc` = `vc` = 0, both FSMs in ACTIVE.
  - `x` = 0, `y` = 0, `frame_active` = 0, `line_start` = 0, `frame_start` = 0.
  - `h_sync` = `v_sync` = inactive level (1 when `SYNC_POL` = 0).
- Latency: outputs reflect the counter state one enabled cycle later.
  - The first enabled cycle after reset release shows `x` = 0, `y` = 0, `frame_active` = 1, `line_start` = 1, `frame_start` = 1.
- Line period is 800 enabled cycles. Frame period is 420 000 enabled cycles.
- Simultaneous events: at `hc` = 799 with `vc` = 524, both counters wrap in the same cycle. The next outputs are `frame_start` = 1 with (0,0).
- Reset asserted mid-line: outputs go to reset values immediately. Scanning restarts at (0,0), with no partial-frame completion.
- When `ce` toggles every cycle (clk = 2× pixel clock), the timing scales exactly. There are no extra pulses or duplicated states.

## Structure
- Package `vga_timing_pkg` holds:
  - the default timing constants and the derived H_TOTAL/V_TOTAL;
  - the phase enum type (ACTIVE, FRONT, SYNC, BACK).
- Sub-module `vga_phase_counter` is parameterized by ACTIVE/FRONT/SYNC/BACK. It is instantiated twice, once per axis.
  - Inputs: `clk`, `rst_n`, `step`.
  - Outputs: count, phase, `wrap`.
  - Horizontal instance: `step` = `ce`.
  - Vertical instance: `step` = `ce` & h `wrap`.
- The top level registers outputs and derives `y` gating and the pulses.

## Test plan
- Reset release with `ce` = 1:
  - first output cycle shows `x` = 0, `y` = 0, `frame_active` = 1, `frame_start` = 1, `h_sync` = 1, `v_sync` = 1;
  - `frame_start` recurs exactly 420 000 cycles later.
- One full line:
  - `frame_active` is high for exactly 640 cycles;
  - `h_sync` is low for exactly 96 cycles, starting at `x` = 656;
  - `line_start` period is 800.
- Full frame:
  - `v_sync` is low for exactly 1600 cycles, starting at line 490, `x` = 0;
  - `y` = 0 and `frame_active` = 0 for all lines 480..524;
  - `y` = 479 on the last active line.
- `ce` = 0 for 37 cycles at `x` = 799, `y` = 479: all outputs are frozen. After `ce` = 1, the next output is `x` = 0, blank line 480, `frame_active` = 0.
- Assert `rst_n` low at `x` = 300, `y` = 200, asynchronously mid-cycle: outputs reach reset values before the next `clk` edge. After release, scanning restarts at (0,0).
- `SYNC_POL` = 1 build: sync idles low and pulses high, at the same positions and widths as the default build.
